// File: rtl/fp_normalize.sv
// fp_normalize: iterative post-add normalizer.
// Takes the adder's raw {exp, mant} word plus its mantissa overflow flag.
// Each cycle it makes one decision: renormalize an overflow, saturate,
// detect zero, stop when normalized, stop on exponent underflow, or shift
// left by one bit. The result is held in DONE until the consumer takes it.
module fp_normalize #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] in_word,
  input  logic                    in_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] out_word,
  output logic                    out_zero,
  output logic                    out_oflow,
  output logic                    out_uflow,
  output logic [CNT_W-1:0]        out_shift
);

  localparam int WORD_W = EXP_W + MANT_W;

  // Exponent limits in two's complement: +max = 0111..1, -max = 1000..0.
  localparam logic [EXP_W-1:0]  EXP_MAX      = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0]  EXP_MIN      = {1'b1, {(EXP_W-1){1'b0}}};
  localparam logic [EXP_W-1:0]  EXP_ONE      = {{(EXP_W-1){1'b0}}, 1'b1};
  // Saturation mantissas: largest positive and most negative values.
  localparam logic [MANT_W-1:0] MANT_POS_SAT = {1'b0, {(MANT_W-1){1'b1}}};
  localparam logic [MANT_W-1:0] MANT_NEG_SAT = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Control state.
  state_e state_q, state_d;

  // Working registers for the operation in flight.
  logic [EXP_W-1:0]  exp_q,  exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              ovf_q,  ovf_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  // Registered result. It is only loaded on the way into DONE, so it stays
  // stable for as long as the consumer stalls.
  logic [WORD_W-1:0] out_word_q,  out_word_d;
  logic              out_zero_q,  out_zero_d;
  logic              out_oflow_q, out_oflow_d;
  logic              out_uflow_q, out_uflow_d;
  logic [CNT_W-1:0]  out_shift_q, out_shift_d;

  // Result of the current SHIFT decision when it terminates the operation.
  logic              finish;
  logic [EXP_W-1:0]  res_exp;
  logic [MANT_W-1:0] res_mant;
  logic              res_zero;
  logic              res_oflow;
  logic              res_uflow;

  // Mantissa is normalized when its two top bits differ.
  logic              mant_normal;
  logic              mant_is_zero;

  assign mant_normal  = mant_q[MANT_W-1] ^ mant_q[MANT_W-2];
  assign mant_is_zero = (mant_q == '0);

  // Next-state, working-register and result logic for the three-state FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case statement so that
    // no path leaves it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_word_d  = out_word_q;
    out_zero_d  = out_zero_q;
    out_oflow_d = out_oflow_q;
    out_uflow_d = out_uflow_q;
    out_shift_d = out_shift_q;
    finish      = 1'b0;
    res_exp     = exp_q;
    res_mant    = mant_q;
    res_zero    = 1'b0;
    res_oflow   = 1'b0;
    res_uflow   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = in_word[WORD_W-1:MANT_W];
          mant_d  = in_word[MANT_W-1:0];
          ovf_d   = in_ovf;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (ovf_q && (exp_q == EXP_MAX)) begin
          // Overflowed mantissa at the top exponent: saturate toward the
          // true sign, which is the inverse of the stored sign bit.
          finish    = 1'b1;
          res_exp   = EXP_MAX;
          res_mant  = mant_q[MANT_W-1] ? MANT_POS_SAT : MANT_NEG_SAT;
          res_oflow = 1'b1;
        end else if (ovf_q) begin
          // Shift right once, restoring the true sign into the top bit.
          finish   = 1'b1;
          res_exp  = exp_q + EXP_ONE;
          res_mant = {~mant_q[MANT_W-1], mant_q[MANT_W-1:1]};
        end else if (mant_is_zero) begin
          // Zero has a canonical all-zero encoding, exponent included.
          finish   = 1'b1;
          res_exp  = '0;
          res_mant = '0;
          res_zero = 1'b1;
        end else if (mant_normal) begin
          finish = 1'b1;
        end else if (exp_q == EXP_MIN) begin
          // Cannot lower the exponent further: leave the value denormal.
          finish    = 1'b1;
          res_uflow = 1'b1;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end

        if (finish) begin
          out_word_d  = {res_exp, res_mant};
          out_zero_d  = res_zero;
          out_oflow_d = res_oflow;
          out_uflow_d = res_uflow;
          out_shift_d = cnt_q;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      mant_q      <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_word_q  <= '0;
      out_zero_q  <= 1'b0;
      out_oflow_q <= 1'b0;
      out_uflow_q <= 1'b0;
      out_shift_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed from the same pre-edge state, independent of order.
      state_q     <= state_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_word_q  <= out_word_d;
      out_zero_q  <= out_zero_d;
      out_oflow_q <= out_oflow_d;
      out_uflow_q <= out_uflow_d;
      out_shift_q <= out_shift_d;
    end
  end

  // Handshake signals decode directly from state so reset drops them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign out_word  = out_word_q;
  assign out_zero  = out_zero_q;
  assign out_oflow = out_oflow_q;
  assign out_uflow = out_uflow_q;
  assign out_shift = out_shift_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Testbench for fp_normalize: directed table, random vectors against a
// value-level reference model, backpressure and asynchronous reset cases.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_zero;
  logic        out_oflow;
  logic        out_uflow;
  logic [4:0]  out_shift;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] word;
    logic        zero;
    logic        oflow;
    logic        uflow;
    logic [4:0]  shift;
    int          lat;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] in_w;
    logic        ovf;
    res_t        exp_r;
  } vec_t;

  fp_normalize #(.EXP_W(8), .MANT_W(24), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_zero  (out_zero),
    .out_oflow (out_oflow),
    .out_uflow (out_uflow),
    .out_shift (out_shift)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input res_t got, input res_t exp);
    check({name, " word"},  got.word,  exp.word);
    check({name, " zero"},  32'(got.zero),  32'(exp.zero));
    check({name, " oflow"}, 32'(got.oflow), 32'(exp.oflow));
    check({name, " uflow"}, 32'(got.uflow), 32'(exp.uflow));
    check({name, " shift"}, 32'(got.shift), 32'(exp.shift));
    check({name, " latency"}, 32'(got.lat), 32'(exp.lat));
  endtask

  // Reference model: works on the numeric values of exponent and mantissa.
  function automatic res_t ref_model(input logic [31:0] w, input logic ovf);
    res_t r;
    int   e;
    int   m;
    logic [7:0]  e8;
    logic [23:0] m24;
    e = int'($signed(w[31:24]));
    m = int'($signed(w[23:0]));
    r.zero = 1'b0; r.oflow = 1'b0; r.uflow = 1'b0;
    r.shift = '0;
    if (ovf) begin
      // True mantissa lives in 25 bits: undo the wrap-around of the adder.
      m = (m < 0) ? m + (1 << 24) : m - (1 << 24);
      if (e == 127) begin
        r.oflow = 1'b1;
        m = (m > 0) ? (1 << 23) - 1 : -(1 << 23);
      end else begin
        m = m >>> 1;
        e = e + 1;
      end
    end else if (m == 0) begin
      e = 0;
      r.zero = 1'b1;
    end else begin
      while (!(m >= (1 << 22) || m < -(1 << 22))) begin
        if (e == -128) begin
          r.uflow = 1'b1;
          break;
        end
        m = m * 2;
        e = e - 1;
        r.shift = r.shift + 5'd1;
      end
    end
    e8  = e[7:0];
    m24 = m[23:0];
    r.word = {e8, m24};
    r.lat  = 2 + int'(r.shift);
    return r;
  endfunction

  // Applies one word from IDLE at a falling edge, waits for the result,
  // consumes it and returns at a falling edge with the DUT back in IDLE.
  task automatic apply(input string name, input logic [31:0] w, input logic ovf, output res_t r);
    in_word  = w;
    in_ovf   = ovf;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r.lat = 1;
    while (!out_valid && r.lat < 40) begin
      @(negedge clk);
      r.lat++;
    end
    r.word  = out_word;
    r.zero  = out_zero;
    r.oflow = out_oflow;
    r.uflow = out_uflow;
    r.shift = out_shift;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  vec_t tbl[7];
  res_t got;
  res_t expr;
  int   spur;

  initial begin
    tbl[0] = '{"norm",     32'h02400000, 1'b0, '{32'h02400000, 1'b0, 1'b0, 1'b0, 5'd0,  2}};
    tbl[1] = '{"smallpos", 32'h04000004, 1'b0, '{32'hF0400000, 1'b0, 1'b0, 1'b0, 5'd20, 22}};
    tbl[2] = '{"minus1",   32'h00FFFFFF, 1'b0, '{32'hE9800000, 1'b0, 1'b0, 1'b0, 5'd23, 25}};
    tbl[3] = '{"ovf",      32'h05A00000, 1'b1, '{32'h06500000, 1'b0, 1'b0, 1'b0, 5'd0,  2}};
    tbl[4] = '{"ovfsat",   32'h7F900000, 1'b1, '{32'h7F7FFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  2}};
    tbl[5] = '{"zero",     32'h7F000000, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 5'd0,  2}};
    tbl[6] = '{"uflow",    32'h81000001, 1'b0, '{32'h80000002, 1'b0, 1'b0, 1'b1, 5'd1,  3}};

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_ovf = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_word",  out_word,       32'd0);
    check("reset flags",     32'({out_zero, out_oflow, out_uflow}), 32'd0);
    check("reset out_shift", 32'(out_shift), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].name, tbl[i].in_w, tbl[i].ovf, got);
      check_res(tbl[i].name, got, tbl[i].exp_r);
    end

    // Random vectors, biased toward small mantissas and exponent limits.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] w;
      logic [23:0] m;
      logic        ovf;
      int          k;
      w   = $urandom;
      ovf = ($urandom_range(0, 3) == 0);
      k   = $urandom_range(0, 23);
      m   = w[23:0];
      m   = $signed(m) >>> k;
      if ($urandom_range(0, 15) == 0) m = '0;
      case ($urandom_range(0, 7))
        0: w[31:24] = 8'h7F;
        1: w[31:24] = 8'h80;
        2: w[31:24] = 8'(128 + $urandom_range(0, 12));
        default: ;
      endcase
      w[23:0] = m;
      expr = ref_model(w, ovf);
      apply("random", w, ovf, got);
      check_res("random", got, expr);
    end

    // Backpressure: result held for 10 cycles while a new word waits.
    in_word = 32'h04000004; in_ovf = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got.lat = 1;
    while (!out_valid && got.lat < 40) begin
      @(negedge clk);
      got.lat++;
    end
    check("bp latency", 32'(got.lat), 32'd22);
    in_word = 32'h02400000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold word",     out_word,        32'hF0400000);
      check("bp hold shift",    32'(out_shift),  32'd20);
      check("bp hold flags",    32'({out_zero, out_oflow, out_uflow}), 32'd0);
      check("bp hold valid",    32'(out_valid),  32'd1);
      check("bp hold in_ready", 32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", 32'(in_ready),  32'd1);
    check("bp release valid",    32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp b2b accepted", 32'(in_ready), 32'd0);
    got.lat = 1;
    while (!out_valid && got.lat < 40) begin
      @(negedge clk);
      got.lat++;
    end
    check("bp b2b latency", 32'(got.lat), 32'd2);
    check("bp b2b word",    out_word,     32'h02400000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset during the 10th shift of 0x04000004.
    in_word = 32'h04000004; in_ovf = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst in_ready",  32'(in_ready),  32'd1);
    check("arst out_word",  out_word,       32'd0);
    check("arst out_shift", 32'(out_shift), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    check("arst no spurious result", 32'(spur), 32'd0);
    apply("arst next", 32'h02400000, 1'b0, got);
    check_res("arst next", got, tbl[0].exp_r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
